ss_player_mover: RTL and testbench

SS_PLAYER_MOVER -- requirements
Module: ss_player_mover

---
 rtl/ss_pkg.sv | 49 ++++
 rtl/ss_probe_timer.sv | 39 +++
 rtl/ss_player_mover.sv | 207 ++++++++++++++++++++
 tb/tb_ss_player_mover.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared types and constants for the side-scroller player mover.
package ss_pkg;

   // Tile codes returned by the world map.
   typedef enum logic [1:0] {
      TILE_OPEN   = 2'b00,
      TILE_SOLID  = 2'b01,
      TILE_HAZARD = 2'b10,
      TILE_GOAL   = 2'b11
   } tile_t;

   // Move-evaluation sequencer states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      H_PROBE = 3'd1,
      H_WAIT  = 3'd2,
      H_CHECK = 3'd3,
      V_PROBE = 3'd4,
      V_WAIT  = 3'd5,
      V_CHECK = 3'd6,
      DONE    = 3'd7
   } state_t;

   // Horizontal request latched when a tick is accepted.
   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2
   } hdir_t;

   // Screen-edge columns: stepping past an edge re-enters on the far side.
   localparam logic [7:0] WRAP_EAST_X  = 8'h7C;
   localparam logic [7:0] WRAP_WEST_X  = 8'h00;
   localparam logic [7:0] ENTRY_WEST_X = 8'h01;
   localparam logic [7:0] ENTRY_EAST_X = 8'h7B;

   // Both buttons or neither cancel each other out.
   function automatic hdir_t decode_hdir(input logic left, input logic right);
      if (left && !right) return DIR_LEFT;
      if (right && !left) return DIR_RIGHT;
      return DIR_NONE;
   endfunction

   // Every tile except SOLID lets the player step into it.
   function automatic logic tile_passable(input tile_t t);
      return (t != TILE_SOLID);
   endfunction

endpackage

// File: rtl/ss_probe_timer.sv
// Loadable down-counter that raises valid_o for one cycle READ_LAT
// cycles after start_i, marking the last wait cycle of a map probe.
// READ_LAT must be at least 1.
module ss_probe_timer #(
   parameter int READ_LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   output logic valid_o
);

   localparam int CW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Load on start, otherwise count down and rest at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = CW'(READ_LAT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign valid_o = (cnt_q == CW'(1));

endmodule

// File: rtl/ss_player_mover.sv
// Player movement engine: on each accepted tick it probes the world map
// once horizontally and once vertically, commits legal steps, and tracks
// jumping, ground contact and the sticky dead/goal flags.
module ss_player_mover
   import ss_pkg::*;
#(
   parameter logic [7:0] START_X    = 8'h01,
   parameter logic [6:0] START_Y    = 7'h40,
   parameter int         READ_LAT   = 2,
   parameter int         JUMP_STEPS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic [1:0]  worldmap_data,
   output logic [7:0]  LocX,
   output logic [6:0]  LocY,
   output logic [13:0] worldmap_addr,
   output logic        busy,
   output logic        dead,
   output logic        goal
);

   localparam int JW = (JUMP_STEPS < 2) ? 1 : $clog2(JUMP_STEPS + 1);

   state_t        state_q,    state_d;
   logic [7:0]    locx_q,     locx_d;
   logic [6:0]    locy_q,     locy_d;
   logic          busy_q,     busy_d;
   logic          dead_q,     dead_d;
   logic          goal_q,     goal_d;
   logic          grounded_q, grounded_d;
   logic [JW-1:0] jump_cnt_q, jump_cnt_d;
   hdir_t         hdir_q,     hdir_d;

   tile_t         tile;
   logic          h_wrap;
   logic          h_probe_en;
   logic          v_up;
   logic          v_probe_en;
   logic [7:0]    h_target;
   logic [6:0]    v_target;
   logic [13:0]   h_addr;
   logic [13:0]   v_addr;
   logic          probe_start;
   logic          probe_valid;

   assign tile = tile_t'(worldmap_data);

   // Horizontal step: wrap at the screen edges instead of probing.
   assign h_wrap = ((hdir_q == DIR_RIGHT) && (locx_q == WRAP_EAST_X)) ||
                   ((hdir_q == DIR_LEFT)  && (locx_q == WRAP_WEST_X));
   assign h_probe_en = (hdir_q != DIR_NONE) && !h_wrap;
   assign h_target   = (hdir_q == DIR_RIGHT) ? (locx_q + 8'd1) : (locx_q - 8'd1);
   assign h_addr     = {locy_q, h_target[6:0]};

   // Vertical step: rise while jump steps remain, otherwise fall.
   // Rising from row 0 or falling from row 7F needs no map lookup.
   assign v_up       = (jump_cnt_q != '0);
   assign v_probe_en = v_up ? (locy_q != 7'h00) : (locy_q != 7'h7F);
   assign v_target   = v_up ? (locy_q - 7'd1) : (locy_q + 7'd1);
   assign v_addr     = {v_target, locx_q[6:0]};

   assign probe_start = ((state_q == H_PROBE) && h_probe_en) ||
                        ((state_q == V_PROBE) && v_probe_en);

   ss_probe_timer #(
      .READ_LAT (READ_LAT)
   ) u_probe_timer (
      .clk     (clk),
      .reset   (reset),
      .start_i (probe_start),
      .valid_o (probe_valid)
   );

   // Sequencer: one horizontal then one vertical evaluation per tick.
   always_comb begin
      state_d    = state_q;
      locx_d     = locx_q;
      locy_d     = locy_q;
      busy_d     = busy_q;
      dead_d     = dead_q;
      goal_d     = goal_q;
      grounded_d = grounded_q;
      jump_cnt_d = jump_cnt_q;
      hdir_d     = hdir_q;
      case (state_q)
         IDLE: begin
            if (tick && !dead_q) begin
               hdir_d  = decode_hdir(btn_left, btn_right);
               busy_d  = 1'b1;
               state_d = H_PROBE;
               // A new jump may start only from the ground, not mid-air.
               if (btn_jump && grounded_q && (jump_cnt_q == '0)) begin
                  jump_cnt_d = JW'(JUMP_STEPS);
               end
            end
         end
         H_PROBE: begin
            if (hdir_q == DIR_NONE) begin
               state_d = V_PROBE;
            end else if (h_wrap) begin
               locx_d  = (hdir_q == DIR_RIGHT) ? ENTRY_WEST_X : ENTRY_EAST_X;
               state_d = V_PROBE;
            end else begin
               state_d = H_WAIT;
            end
         end
         H_WAIT: begin
            if (probe_valid) state_d = H_CHECK;
         end
         H_CHECK: begin
            state_d = V_PROBE;
            if (tile_passable(tile)) locx_d = h_target;
            if (tile == TILE_GOAL)   goal_d = 1'b1;
            if (tile == TILE_HAZARD) begin
               dead_d  = 1'b1;
               state_d = DONE;
            end
         end
         V_PROBE: begin
            if (v_probe_en) begin
               state_d = V_WAIT;
            end else if (v_up) begin
               // Head against the top row: the jump ends here.
               jump_cnt_d = '0;
               state_d    = DONE;
            end else begin
               // Falling off the bottom row is fatal.
               dead_d  = 1'b1;
               state_d = DONE;
            end
         end
         V_WAIT: begin
            if (probe_valid) state_d = V_CHECK;
         end
         V_CHECK: begin
            state_d = DONE;
            if (tile_passable(tile)) begin
               locy_d     = v_target;
               grounded_d = 1'b0;
               if (v_up) jump_cnt_d = jump_cnt_q - JW'(1);
               if (tile == TILE_GOAL)   goal_d = 1'b1;
               if (tile == TILE_HAZARD) dead_d = 1'b1;
            end else if (v_up) begin
               jump_cnt_d = '0;
            end else begin
               grounded_d = 1'b1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset abandons any evaluation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         locx_q     <= START_X;
         locy_q     <= START_Y;
         busy_q     <= 1'b0;
         dead_q     <= 1'b0;
         goal_q     <= 1'b0;
         grounded_q <= 1'b0;
         jump_cnt_q <= '0;
         hdir_q     <= DIR_NONE;
      end else begin
         state_q    <= state_d;
         locx_q     <= locx_d;
         locy_q     <= locy_d;
         busy_q     <= busy_d;
         dead_q     <= dead_d;
         goal_q     <= goal_d;
         grounded_q <= grounded_d;
         jump_cnt_q <= jump_cnt_d;
         hdir_q     <= hdir_d;
      end
   end

   // Map address: the probe target while probing, the player tile otherwise.
   always_comb begin
      worldmap_addr = {locy_q, locx_q[6:0]};
      case (state_q)
         H_PROBE:         if (h_probe_en) worldmap_addr = h_addr;
         H_WAIT, H_CHECK: worldmap_addr = h_addr;
         V_PROBE:         if (v_probe_en) worldmap_addr = v_addr;
         V_WAIT, V_CHECK: worldmap_addr = v_addr;
         default:         worldmap_addr = {locy_q, locx_q[6:0]};
      endcase
   end

   assign LocX = locx_q;
   assign LocY = locy_q;
   assign busy = busy_q;
   assign dead = dead_q;
   assign goal = goal_q;

endmodule

// File: tb/tb_ss_player_mover.sv
// Randomized and directed bench for ss_player_mover against a
// tick-level behavioural model of the player rules.
module tb_ss_player_mover;

   localparam int RL = 2;
   localparam int JS = 4;
   localparam int T_OPEN = 0, T_SOLID = 1, T_HAZARD = 2, T_GOAL = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
   logic [1:0]  worldmap_data;
   logic [7:0]  LocX;
   logic [6:0]  LocY;
   logic [13:0] worldmap_addr;
   logic        busy, dead, goal;

   ss_player_mover #(
      .START_X    (8'h01),
      .START_Y    (7'h40),
      .READ_LAT   (RL),
      .JUMP_STEPS (JS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_jump      (btn_jump),
      .worldmap_data (worldmap_data),
      .LocX          (LocX),
      .LocY          (LocY),
      .worldmap_addr (worldmap_addr),
      .busy          (busy),
      .dead          (dead),
      .goal          (goal)
   );

   always #5 clk = ~clk;

   // World map with READ_LAT cycles of address-to-data latency.
   logic [1:0]  wmap [0:127][0:127];
   logic [13:0] addr_pipe [RL];

   always @(posedge clk) begin
      addr_pipe[0] <= worldmap_addr;
      for (int i = 1; i < RL; i++) addr_pipe[i] <= addr_pipe[i-1];
   end
   assign worldmap_data = wmap[addr_pipe[RL-1][13:7]][addr_pipe[RL-1][6:0]];

   int tests_run = 0;
   int tests_failed = 0;
   int n_trans = 0;

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference player state.
   int m_x, m_y, m_jump;
   bit m_dead, m_goal, m_ground;

   task automatic model_reset();
      m_x = 'h01; m_y = 'h40; m_jump = 0;
      m_dead = 0; m_goal = 0; m_ground = 0;
   endtask

   // Applies one tick to the model; cyc = expected number of busy cycles.
   task automatic model_tick(input bit l, input bit r, input bit j, output int cyc);
      int dir, tcol, t;
      cyc = 0;
      if (m_dead) return;
      if (j && m_ground && m_jump == 0) m_jump = JS;
      cyc = 1;
      dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
      if (dir == 0) begin
         cyc += 1;
      end else if (dir == 1 && m_x == 'h7C) begin
         m_x = 'h01; cyc += 1;
      end else if (dir == -1 && m_x == 0) begin
         m_x = 'h7B; cyc += 1;
      end else begin
         cyc += RL + 2;
         tcol = m_x + dir;
         t = int'(wmap[m_y][tcol % 128]);
         if (t != T_SOLID) m_x = tcol;
         if (t == T_GOAL) m_goal = 1;
         if (t == T_HAZARD) begin
            m_dead = 1;
            return;
         end
      end
      if (m_jump > 0) begin
         if (m_y == 0) begin
            m_jump = 0; cyc += 1;
         end else begin
            cyc += RL + 2;
            t = int'(wmap[m_y-1][m_x % 128]);
            if (t != T_SOLID) begin
               m_y--; m_jump--; m_ground = 0;
               if (t == T_GOAL) m_goal = 1;
               if (t == T_HAZARD) m_dead = 1;
            end else begin
               m_jump = 0;
            end
         end
      end else begin
         if (m_y == 127) begin
            m_dead = 1; cyc += 1;
         end else begin
            cyc += RL + 2;
            t = int'(wmap[m_y+1][m_x % 128]);
            if (t != T_SOLID) begin
               m_y++; m_ground = 0;
               if (t == T_GOAL) m_goal = 1;
               if (t == T_HAZARD) m_dead = 1;
            end else begin
               m_ground = 1;
            end
         end
      end
   endtask

   task automatic check_state(input string when);
      check({when, "_LocX"}, int'(LocX), m_x);
      check({when, "_LocY"}, int'(LocY), m_y);
      check({when, "_dead"}, int'(dead), int'(m_dead));
      check({when, "_goal"}, int'(goal), int'(m_goal));
      check({when, "_busy"}, int'(busy), 0);
      check({when, "_addr"}, int'(worldmap_addr), m_y * 128 + (m_x % 128));
   endtask

   // Issue one tick, scramble buttons while busy, count busy cycles.
   task automatic do_tick(input bit l, input bit r, input bit j, input int extra_at,
                          input int forbid, output int cyc, output bit saw);
      @(negedge clk);
      btn_left = l; btn_right = r; btn_jump = j; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      cyc = 0;
      saw = 0;
      while (busy && cyc < 64) begin
         cyc++;
         if (int'(worldmap_addr) == forbid) saw = 1;
         tick = (cyc == extra_at);
         btn_left = 1'($urandom); btn_right = 1'($urandom); btn_jump = 1'($urandom);
         @(negedge clk);
      end
      tick = 1'b0;
   endtask

   task automatic run_tick(input bit l, input bit r, input bit j, input int extra_at, input int forbid);
      int exp_cyc, got_cyc;
      bit saw;
      model_tick(l, r, j, exp_cyc);
      do_tick(l, r, j, extra_at, forbid, got_cyc, saw);
      check("busy_cycles", got_cyc, exp_cyc);
      check_state("tick");
      if (forbid >= 0) check("no_hprobe", int'(saw), 0);
      n_trans++;
      $display("[TB] tick %0d l=%0b r=%0b j=%0b -> X=%02h Y=%02h dead=%0b goal=%0b busy_cyc=%0d",
               n_trans, l, r, j, LocX, LocY, dead, goal, got_cyc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check_state("reset");
      n_trans++;
      $display("[TB] reset %0d -> X=%02h Y=%02h", n_trans, LocX, LocY);
   endtask

   // Tick then reset after wait_n further cycles, aborting the evaluation.
   task automatic run_abort(input bit l, input bit r, input bit j, input int wait_n);
      @(negedge clk);
      btn_left = l; btn_right = r; btn_jump = j; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (wait_n) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check_state("abort");
      n_trans++;
      $display("[TB] abort %0d after %0d cycles -> X=%02h Y=%02h busy=%0b", n_trans, wait_n + 1, LocX, LocY, busy);
   endtask

   task automatic fill_map(input int solid_row);
      for (int y = 0; y < 128; y++)
         for (int x = 0; x < 128; x++)
            wmap[y][x] = (y == solid_row) ? 2'(T_SOLID) : 2'(T_OPEN);
   endtask

   initial begin
      int guard, pick;
      fill_map('h41);
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_state("por");

      // Walk right along the floor to the east edge.
      guard = 0;
      while (m_x != 'h7C && guard < 200) begin
         run_tick(0, 1, 0, 0, -1);
         guard++;
      end
      check("walk_reached_east", int'(LocX), 'h7C);

      // Edge wraps: no probe of the column beyond the edge.
      run_tick(0, 1, 0, 0, 'h40 * 128 + 'h7D);
      check("wrap_east", int'(LocX), 'h01);
      run_tick(1, 0, 0, 0, -1);
      run_tick(1, 0, 0, 0, 'h40 * 128 + 'h7F);
      check("wrap_west", int'(LocX), 'h7B);

      // Jump from the floor: four rises, then fall back to the floor.
      for (int k = 0; k < 4; k++) begin
         run_tick(0, 0, 1, 0, -1);
         check("jump_rise", int'(LocY), 'h3F - k);
      end
      for (int k = 0; k < 5; k++) run_tick(0, 0, 0, 0, -1);
      check("jump_landed", int'(LocY), 'h40);

      // A second tick while busy is dropped.
      run_tick(0, 1, 0, 3, -1);
      run_tick(1, 0, 0, 9, -1);

      // Reset in H_WAIT after one committed move.
      do_reset();
      run_tick(0, 1, 0, 0, -1);
      run_abort(0, 1, 0, 1);
      check("abort_hwait_x", int'(LocX), 'h01);

      // Goal then hazard.
      wmap['h40]['h02] = 2'(T_GOAL);
      run_tick(0, 1, 0, 0, -1);
      wmap['h40]['h03] = 2'(T_HAZARD);
      run_tick(0, 1, 0, 0, -1);
      check("hazard_dead", int'(dead), 1);
      run_tick(1, 0, 0, 0, -1);
      run_tick(0, 0, 1, 0, -1);

      // Fall through an empty world off the bottom row.
      fill_map(-1);
      do_reset();
      guard = 0;
      while (!m_dead && guard < 80) begin
         run_tick(0, 0, 0, 0, -1);
         guard++;
      end
      check("fell_out_dead", int'(dead), 1);

      // Random world and random play.
      for (int y = 0; y < 128; y++)
         for (int x = 0; x < 128; x++) begin
            pick = int'($urandom_range(0, 99));
            wmap[y][x] = (pick < 62) ? 2'(T_OPEN) : (pick < 94) ? 2'(T_SOLID) :
                         (pick < 97) ? 2'(T_GOAL) : 2'(T_HAZARD);
         end
      do_reset();
      for (int n = 0; n < 250; n++) begin
         pick = int'($urandom_range(0, 39));
         if (m_dead) begin
            run_tick(1'($urandom), 1'($urandom), 1'($urandom), 0, -1);
            do_reset();
         end else if (pick == 0) begin
            do_reset();
         end else if (pick < 3) begin
            run_abort(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 9)));
         end else begin
            run_tick(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 10)), -1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
